// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host command sequencer.
// Imported by the top and the transmit shifter.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StSend,
        StAck,
        StWaitResp,
        StDone
    } ps2_state_e;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_NOACK   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_RETRY   = 2'b11;

    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;

    function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_host_ctrl_if.sv
// Command handshake and status bundle between a command source and the PS/2 host sequencer.
// master issues commands; slave is the sequencer.
interface ps2_host_ctrl_if;

    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       cmd_ready;
    logic       busy;
    logic       cmd_done;
    logic       cmd_err;
    logic [1:0] err_code;

    modport master (
        output cmd_valid, cmd_byte,
        input  cmd_ready, busy, cmd_done, cmd_err, err_code
    );

    modport slave (
        input  cmd_valid, cmd_byte,
        output cmd_ready, busy, cmd_done, cmd_err, err_code
    );

endinterface

// File: rtl/ps2_tx_shift.sv
// Host-to-device bit shifter: start bit on load, then data LSB first, odd parity and stop,
// one bit per device clock falling edge.
module ps2_tx_shift
    import ps2_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       advance,
    input  logic       clear,
    output logic       d_oe,
    output logic       last_bit
);

    logic [9:0] seq_q;
    logic [3:0] idx_q;
    logic       d_oe_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_q  <= '0;
            idx_q  <= '0;
            d_oe_q <= 1'b0;
        end else if (clear) begin
            idx_q  <= '0;
            d_oe_q <= 1'b0;
        end else if (load) begin
            // Line levels in send order: data[7:0], odd parity, stop (released high).
            seq_q  <= {1'b1, ~^data, data};
            idx_q  <= '0;
            d_oe_q <= 1'b1;
        end else if (advance && idx_q != 4'd10) begin
            d_oe_q <= ~seq_q[idx_q];
            idx_q  <= idx_q + 4'd1;
        end
    end

    assign d_oe = d_oe_q;
    // High while the next advance shifts out the stop bit.
    assign last_bit = (idx_q == 4'd9);

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host sequencer: sends one command byte with the full host-to-device protocol,
// waits for ACK/Resend from the receive path, retries and reports status.
module ps2_host_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYC = 10000,
    parameter int unsigned RTS_CYC     = 20,
    parameter int unsigned QUIET_CYC   = 10000,
    parameter int unsigned TIMEOUT_CYC = 2000000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic           clk,
    input  logic           rst,
    ps2_host_ctrl_if.slave cmd,
    input  logic           fall_edge,
    input  logic           ps2_d_in,
    input  logic           rx_done,
    input  logic [7:0]     rx_data,
    output logic           ps2_c_oe,
    output logic           ps2_d_oe,
    output logic           tx_idle
);

    localparam int unsigned CntMax =
        max_of(max_of(INHIBIT_CYC, RTS_CYC), max_of(QUIET_CYC, TIMEOUT_CYC));
    localparam int unsigned CntW   = $clog2(CntMax) + 1;
    localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

    localparam logic [CntW-1:0]   InhLast  = CntW'(INHIBIT_CYC - 1);
    localparam logic [CntW-1:0]   RtsLast  = CntW'(RTS_CYC - 1);
    localparam logic [CntW-1:0]   ToLast   = CntW'(TIMEOUT_CYC - 1);
    localparam logic [CntW-1:0]   QuietMax = CntW'(QUIET_CYC);
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

    ps2_state_e        state_q;
    logic [CntW-1:0]   cnt_q;
    logic [CntW-1:0]   quiet_q;
    logic [RetryW-1:0] retry_q;
    logic [7:0]        byte_q;
    logic              c_oe_q, tx_idle_q, busy_q, done_q, err_q;
    logic [1:0]        code_q;

    logic       resp_ok, resp_rs, retry_ok, timeout, load, advance, last_bit;
    logic       fin;
    logic [1:0] fin_code;

    assign resp_ok  = (state_q == StWaitResp) && rx_done && (rx_data == PS2_ACK);
    assign resp_rs  = (state_q == StWaitResp) && rx_done && (rx_data == PS2_RESEND);
    assign retry_ok = resp_rs && (retry_q < RetryMax);
    // cnt_q doubles as the watchdog in the device-clocked states.
    assign timeout  = (state_q == StSend || state_q == StAck || state_q == StWaitResp) &&
                      !fall_edge && (cnt_q == ToLast);
    assign load     = (state_q == StInhibit) && (cnt_q == InhLast);
    assign advance  = (state_q == StSend) && fall_edge;

    always_comb begin
        fin      = 1'b0;
        fin_code = ERR_OK;
        if (resp_ok) begin
            fin = 1'b1;
        end else if (resp_rs) begin
            fin      = !retry_ok;
            fin_code = ERR_RETRY;
        end else if (state_q == StAck && fall_edge && ps2_d_in) begin
            fin      = 1'b1;
            fin_code = ERR_NOACK;
        end else if (timeout) begin
            fin      = 1'b1;
            fin_code = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quiet_q <= '0;
        end else if (fall_edge) begin
            quiet_q <= '0;
        end else if (quiet_q != QuietMax) begin
            quiet_q <= quiet_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            retry_q   <= '0;
            byte_q    <= '0;
            c_oe_q    <= 1'b0;
            tx_idle_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= ERR_OK;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= cnt_q + CntW'(1);
            if (fin) begin
                state_q   <= StDone;
                c_oe_q    <= 1'b0;
                tx_idle_q <= 1'b1;
                done_q    <= 1'b1;
                err_q     <= (fin_code != ERR_OK);
                code_q    <= fin_code;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (cmd.cmd_valid && cmd.cmd_ready) begin
                            byte_q    <= cmd.cmd_byte;
                            retry_q   <= '0;
                            state_q   <= StInhibit;
                            cnt_q     <= '0;
                            c_oe_q    <= 1'b1;
                            tx_idle_q <= 1'b0;
                            busy_q    <= 1'b1;
                        end
                    end
                    StInhibit: begin
                        if (cnt_q == InhLast) begin
                            state_q <= StRts;
                            cnt_q   <= '0;
                        end
                    end
                    StRts: begin
                        if (cnt_q == RtsLast) begin
                            state_q <= StSend;
                            cnt_q   <= '0;
                            c_oe_q  <= 1'b0;
                        end
                    end
                    StSend: begin
                        if (fall_edge) begin
                            cnt_q <= '0;
                            if (last_bit) state_q <= StAck;
                        end
                    end
                    StAck: begin
                        if (fall_edge) begin
                            state_q   <= StWaitResp;
                            cnt_q     <= '0;
                            tx_idle_q <= 1'b1;
                        end
                    end
                    StWaitResp: begin
                        if (retry_ok) begin
                            retry_q   <= retry_q + RetryW'(1);
                            state_q   <= StInhibit;
                            cnt_q     <= '0;
                            c_oe_q    <= 1'b1;
                            tx_idle_q <= 1'b0;
                        end else if (fall_edge) begin
                            cnt_q <= '0;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    ps2_tx_shift u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data     (byte_q),
        .advance  (advance),
        .clear    (fin),
        .d_oe     (ps2_d_oe),
        .last_bit (last_bit)
    );

    assign ps2_c_oe      = c_oe_q;
    assign tx_idle       = tx_idle_q;
    assign cmd.cmd_ready = (state_q == StIdle) && (quiet_q == QuietMax);
    assign cmd.busy      = busy_q;
    assign cmd.cmd_done  = done_q;
    assign cmd.cmd_err   = err_q;
    assign cmd.err_code  = code_q;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Bench for ps2_host_ctrl: a simple PS/2 device model clocks frames out of the host and
// answers with ACK/Resend; results are compared against rules computed here.
module tb_ps2_host_ctrl;

    localparam int INH   = 40;
    localparam int RTS   = 6;
    localparam int QUIET = 30;
    localparam int TO    = 400;
    localparam int MAXR  = 3;
    localparam int GAP   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fall_edge = 1'b0;
    logic       ps2_d_in = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       ps2_c_oe, ps2_d_oe, tx_idle;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ps2_host_ctrl_if bus ();

    ps2_host_ctrl #(
        .INHIBIT_CYC (INH),
        .RTS_CYC     (RTS),
        .QUIET_CYC   (QUIET),
        .TIMEOUT_CYC (TO),
        .MAX_RETRY   (MAXR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (bus),
        .fall_edge (fall_edge),
        .ps2_d_in  (ps2_d_in),
        .rx_done   (rx_done),
        .rx_data   (rx_data),
        .ps2_c_oe  (ps2_c_oe),
        .ps2_d_oe  (ps2_d_oe),
        .tx_idle   (tx_idle)
    );

    // Line levels a device should see: data LSB first, odd parity, stop high.
    function automatic logic [9:0] exp_line(input logic [7:0] b);
        int ones;
        ones = $countones(b);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
    endfunction

    function automatic logic [1:0] exp_code(input int n_fe, input bit ack_ok);
        if (!ack_ok) return 2'b01;
        if (n_fe > MAXR) return 2'b11;
        return 2'b00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_edge(input logic d_level);
        ps2_d_in  = d_level;
        fall_edge = 1'b1;
        tick();
        fall_edge = 1'b0;
        ps2_d_in  = 1'b1;
    endtask

    // Device clocks n falling edges; edge 11 is the ack edge.
    task automatic dev_clock(input int n, input logic ack_level, output logic [9:0] line);
        line = '0;
        for (int k = 1; k <= n; k++) begin
            repeat (GAP) tick();
            if (k == 11) begin
                pulse_edge(ack_level);
            end else begin
                pulse_edge(1'b1);
                line[k-1] = ~ps2_d_oe;
            end
        end
    endtask

    task automatic dev_resp(input logic [7:0] b);
        repeat (GAP) tick();
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic issue(input logic [7:0] b, output bit ok);
        int n;
        n = 0;
        while (!bus.cmd_ready && n < QUIET + 20) begin
            tick();
            n++;
        end
        ok = bus.cmd_ready;
        bus.cmd_valid = 1'b1;
        bus.cmd_byte  = b;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Measures the clock-inhibit phase; injects a stray edge and ACK byte that must be ignored.
    task automatic host_phase(output int c_len, output int d_first);
        c_len   = 0;
        d_first = -1;
        while (ps2_c_oe && c_len < INH + RTS + 20) begin
            if (ps2_d_oe && d_first < 0) d_first = c_len;
            if (c_len == 5) begin
                fall_edge = 1'b1;
                rx_done   = 1'b1;
                rx_data   = 8'hFA;
            end
            c_len++;
            tick();
            fall_edge = 1'b0;
            rx_done   = 1'b0;
        end
    endtask

    task automatic wait_done(input int limit, output int n, output bit seen);
        n = 0;
        while (!bus.cmd_done && n < limit) begin
            tick();
            n++;
        end
        seen = bus.cmd_done;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_byte  = 8'h00;
        repeat (3) tick();
        total++;
        if (ps2_c_oe !== 1'b0 || ps2_d_oe !== 1'b0 || tx_idle !== 1'b1) begin
            bad++;
            $display("FAIL reset_lines got c=%b d=%b idle=%b want c=0 d=0 idle=1",
                     ps2_c_oe, ps2_d_oe, tx_idle);
        end
        total++;
        if ({bus.busy, bus.cmd_ready, bus.cmd_done, bus.cmd_err, bus.err_code} !== 6'b0) begin
            bad++;
            $display("FAIL reset_status got busy=%b rdy=%b done=%b err=%b code=%b want all 0",
                     bus.busy, bus.cmd_ready, bus.cmd_done, bus.cmd_err, bus.err_code);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_transfer(input logic [7:0] b, input int n_fe, input bit ack_ok);
        bit         ok, seen, fin;
        int         c_len, d_first, n, phases;
        logic [9:0] line;
        logic [7:0] junk;
        logic [1:0] code;
        code = exp_code(n_fe, ack_ok);
        issue(b, ok);
        total++;
        if (!ok || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL accept got rdy=%b busy=%b want 1 1", ok, bus.busy);
        end
        phases = 0;
        fin    = 1'b0;
        while (!fin) begin
            phases++;
            total++;
            if (tx_idle !== 1'b0) begin
                bad++;
                $display("FAIL inhibit_idle got=%b want=0", tx_idle);
            end
            host_phase(c_len, d_first);
            total++;
            if (c_len != INH + RTS) begin
                bad++;
                $display("FAIL c_oe_len got=%0d want=%0d", c_len, INH + RTS);
            end
            total++;
            if (d_first != INH) begin
                bad++;
                $display("FAIL rts_start got=%0d want=%0d", d_first, INH);
            end
            dev_clock(11, ack_ok ? 1'b0 : 1'b1, line);
            total++;
            if (line !== exp_line(b)) begin
                bad++;
                $display("FAIL frame_bits got=%b want=%b", line, exp_line(b));
            end
            if (!ack_ok) begin
                fin = 1'b1;
            end else begin
                total++;
                if (tx_idle !== 1'b1) begin
                    bad++;
                    $display("FAIL wait_idle got=%b want=1", tx_idle);
                end
                do junk = 8'($urandom); while (junk == 8'hFA || junk == 8'hFE);
                dev_resp(junk);
                total++;
                if (bus.cmd_done !== 1'b0 || bus.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL junk_resp got done=%b busy=%b want 0 1",
                             bus.cmd_done, bus.busy);
                end
                dev_resp((phases - 1 < n_fe) ? 8'hFE : 8'hFA);
                if (phases - 1 >= n_fe || phases - 1 >= MAXR) fin = 1'b1;
            end
        end
        wait_done(TO, n, seen);
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL done_seen got=0 want=1");
        end
        total++;
        if (bus.cmd_err !== (code != 2'b00) || bus.err_code !== code) begin
            bad++;
            $display("FAIL status got err=%b code=%b want err=%b code=%b",
                     bus.cmd_err, bus.err_code, code != 2'b00, code);
        end
        total++;
        if (ps2_c_oe !== 1'b0 || ps2_d_oe !== 1'b0 || tx_idle !== 1'b1) begin
            bad++;
            $display("FAIL done_lines got c=%b d=%b idle=%b want 0 0 1",
                     ps2_c_oe, ps2_d_oe, tx_idle);
        end
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.cmd_done !== 1'b0 || bus.err_code !== code) begin
            bad++;
            $display("FAIL after_done got busy=%b done=%b code=%b want 0 0 %b",
                     bus.busy, bus.cmd_done, bus.err_code, code);
        end
    endtask

    task automatic test_watchdog();
        bit         ok, seen;
        int         c_len, d_first, n;
        logic [9:0] line;
        issue(8'h0F, ok);
        host_phase(c_len, d_first);
        dev_clock(5, 1'b1, line);
        total++;
        if (ps2_d_oe !== 1'b1) begin
            bad++;
            $display("FAIL wd_drive got=%b want=1", ps2_d_oe);
        end
        wait_done(TO + 50, n, seen);
        total++;
        if (!seen || n != TO) begin
            bad++;
            $display("FAIL wd_delay got seen=%b n=%0d want seen=1 n=%0d", seen, n, TO);
        end
        total++;
        if (bus.cmd_err !== 1'b1 || bus.err_code !== 2'b10) begin
            bad++;
            $display("FAIL wd_code got err=%b code=%b want 1 10", bus.cmd_err, bus.err_code);
        end
        total++;
        if (ps2_c_oe !== 1'b0 || ps2_d_oe !== 1'b0 || tx_idle !== 1'b1) begin
            bad++;
            $display("FAIL wd_lines got c=%b d=%b idle=%b want 0 0 1",
                     ps2_c_oe, ps2_d_oe, tx_idle);
        end
        tick();
    endtask

    // Leaves a command (byte 0x00) accepted for test_reset_mid to abort.
    task automatic test_quiet();
        bit hold;
        int n;
        hold = 1'b1;
        pulse_edge(1'b1);
        bus.cmd_byte  = 8'h00;
        bus.cmd_valid = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < QUIET / 2; i++) begin
                if (bus.cmd_ready || bus.busy) hold = 1'b0;
                tick();
            end
            pulse_edge(1'b1);
        end
        total++;
        if (!hold) begin
            bad++;
            $display("FAIL quiet_block got accepted=1 want=0");
        end
        n = 0;
        while (!bus.cmd_ready && n < QUIET + 10) begin
            tick();
            n++;
        end
        total++;
        if (n != QUIET) begin
            bad++;
            $display("FAIL quiet_len got=%0d want=%0d", n, QUIET);
        end
        tick();
        bus.cmd_valid = 1'b0;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL quiet_accept got busy=%b want=1", bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        int         c_len, d_first, n;
        logic [9:0] line;
        host_phase(c_len, d_first);
        dev_clock(3, 1'b1, line);
        total++;
        if (ps2_d_oe !== 1'b1 || tx_idle !== 1'b0) begin
            bad++;
            $display("FAIL pre_reset got d=%b idle=%b want 1 0", ps2_d_oe, tx_idle);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (ps2_c_oe !== 1'b0 || ps2_d_oe !== 1'b0 || tx_idle !== 1'b1 || bus.busy !== 1'b0)
        begin
            bad++;
            $display("FAIL async_reset got c=%b d=%b idle=%b busy=%b want 0 0 1 0",
                     ps2_c_oe, ps2_d_oe, tx_idle, bus.busy);
        end
        tick();
        rst = 1'b1;
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b0 || bus.err_code !== 2'b00) begin
            bad++;
            $display("FAIL post_reset got busy=%b rdy=%b code=%b want 0 0 00",
                     bus.busy, bus.cmd_ready, bus.err_code);
        end
        n = 0;
        while (!bus.cmd_ready && n < QUIET + 5) begin
            tick();
            n++;
        end
        total++;
        if (bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_idle got rdy=%b want=1", bus.cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_transfer(8'hED, 0, 1'b1);
        test_transfer(8'($urandom), 2, 1'b1);
        test_transfer(8'($urandom), 4, 1'b1);
        test_transfer(8'($urandom), 0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            test_transfer(8'($urandom), int'($urandom_range(0, 4)), $urandom_range(0, 5) != 0);
        end
        test_watchdog();
        test_quiet();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_ctrl.md
Name: ps2_host_ctrl

Overview:
- Host-side sequencer for the PS/2 port; arbitrates the shared ps2_c/ps2_d lines between device-to-host reception and host-to-device command transmission.
- Accepts one command byte at a time and runs the full host-to-device protocol: inhibit, request-to-send, 11-bit shift, ack check.
- Waits for the device response byte from the existing receive path (rx_done/dataout), retries on Resend, and reports status.
- Drives tx_idle into the receive FSM so reception is gated off while the host owns the bus.

Parameters:
- INHIBIT_CYC, 10000, clock held low before RTS (100 us at 100 MHz)
- RTS_CYC, 20, data held low with clock still low before releasing clock
- QUIET_CYC, 10000, cycles with no ps2_c falling edge before the bus counts as idle
- TIMEOUT_CYC, 2000000, watchdog limit in SEND/ACK (between edges) and in WAIT_RESP (20 ms)
- MAX_RETRY, 3, number of re-sends allowed after 0xFE

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_byte  in  8  command to send, captured when cmd_valid&&cmd_ready
- cmd_ready  out  1  high only in IDLE with bus quiet
- fall_edge  in  1  one-cycle pulse per filtered ps2_c falling edge
- ps2_d_in  in  1  synchronised ps2_d level
- rx_done  in  1  one-cycle pulse, byte received
- rx_data  in  8  received byte, valid with rx_done
- ps2_c_oe  out  1  1 = drive ps2_c low, 0 = release
- ps2_d_oe  out  1  1 = drive ps2_d low, 0 = release
- tx_idle  out  1  1 = receiver enabled
- busy  out  1  high outside IDLE
- cmd_done  out  1  one-cycle completion pulse
- cmd_err  out  1  valid with cmd_done; 1 = failure
- err_code  out  2  00 ok, 01 no ack bit, 10 timeout, 11 retries exhausted; held until next cmd_done

Behaviour:
Reset values:
- ps2_c_oe=0, ps2_d_oe=0, tx_idle=1, busy=0, cmd_ready=0, cmd_done=0, cmd_err=0, err_code=00.
- Retry count cleared, quiet counter cleared.
- Reset asserted mid-frame releases both lines immediately (asynchronously).

Quiet counter:
- Counts up to QUIET_CYC; saturates at QUIET_CYC.
- Cleared by every fall_edge in any state.
- cmd_ready = (state==IDLE) && (quiet==QUIET_CYC).

States:
- IDLE: on accept, latch byte, retry=0, go to INHIBIT.
- INHIBIT: ps2_c_oe=1, tx_idle=0; after INHIBIT_CYC cycles go to RTS.
- RTS: ps2_c_oe=1, ps2_d_oe=1 (start bit); after RTS_CYC cycles set ps2_c_oe=0 and go to SEND with bit index 0.
- SEND:
  - On fall_edge k=1..8, put data bit k-1 on ps2_d (ps2_d_oe=~bit).
  - On k=9, put odd parity (parity bit = ~^byte).
  - On k=10, release data (stop bit).
  - Then go to ACK.
- ACK: on the next fall_edge sample ps2_d_in.
  - 0: go to WAIT_RESP, tx_idle=1.
  - 1: error 01.
- WAIT_RESP: on rx_done:
  - 0xFA: success.
  - 0xFE: if retry<MAX_RETRY, increment retry and go to INHIBIT; otherwise error 11.
  - Any other byte: ignored.
- DONE: one cycle; pulse cmd_done (cmd_err=(err_code!=00)), then go to IDLE.

Watchdog:
- Reloaded on state entry and on every fall_edge.
- Expiry in SEND, ACK or WAIT_RESP releases both lines, sets error 10 and goes to DONE.
- Not active in INHIBIT or RTS.

Edge cases:
- rx_done outside WAIT_RESP is ignored.
- fall_edge during INHIBIT/RTS is ignored.
- cmd_valid while busy is not accepted.
- Every error path releases both lines before DONE.

Widths:
- Counters are $clog2(max parameter)+1 bits.
- Bit index is 4 bits.
- Retry counter is $clog2(MAX_RETRY+1) bits.

Decomposition:
- Package ps2_pkg: state enum, err_code constants, PS2_ACK=8'hFA, PS2_RESEND=8'hFE.
- Sub-module ps2_tx_shift: loads a byte, builds the 10-bit data/parity/stop sequence, and advances on fall_edge. Outputs d_oe and last_bit.

Test Plan:
- Idle bus, cmd 0xED → ps2_c_oe high 10000 cycles; ps2_d_oe rises 20 cycles before clock release; device model sees bits 1,0,1,1,0,1,1,1, parity 1, stop; ack 0; rx 0xFA → cmd_done=1, cmd_err=0, err_code=00.
- Device responds 0xFE twice then 0xFA → two extra INHIBIT phases; success, err_code=00. Responding 0xFE four times → err_code=11.
- Device leaves ps2_d high at the ack edge → cmd_done with err_code=01; both oe=0.
- Device stops clocking after edge 5 → watchdog fires after 2000000 cycles; err_code=10, lines released, tx_idle=1.
- fall_edge every 5000 cycles while cmd_valid=1 → cmd_ready stays 0. After the last edge, accept occurs exactly QUIET_CYC cycles later.
- Assert rst during SEND → ps2_c_oe=0, ps2_d_oe=0, tx_idle=1 in the same cycle. After release, state is IDLE with busy=0.
